// File: rtl/laser_setup_pkg.sv
// laser_setup_pkg: shared types and constants for the laser projector setup path.
//   state_e       - alignment sequencer states
//   corner_idx_t  - index of a projection-field corner (0..3)
//   DefaultCoordW - galvo DAC coordinate width, shared with the DAC driver
package laser_setup_pkg;

   localparam int unsigned DefaultCoordW = 12;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StDwell,
      StNext,
      StDone
   } state_e;

   typedef logic [1:0] corner_idx_t;

   // Counter width for a count of n, never narrower than one bit.
   function automatic int unsigned cnt_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/setup_sequencer_if.sv
// setup_sequencer_if: galvo point handshake between the setup sequencer and the DAC driver.
//   point_x/point_y - galvo codes, stable while point_valid is high
//   point_valid     - point offered, held until accepted
//   point_ready     - DAC driver accepts the point
// master = sequencer side, slave = DAC driver side.
interface setup_sequencer_if #(
   parameter int unsigned COORD_W = laser_setup_pkg::DefaultCoordW
);
   logic [COORD_W-1:0] point_x;
   logic [COORD_W-1:0] point_y;
   logic               point_valid;
   logic               point_ready;

   modport master (output point_x, point_y, point_valid, input point_ready);
   modport slave  (input point_x, point_y, point_valid, output point_ready);
endinterface

// File: rtl/setup_corner_lut.sv
// setup_corner_lut: maps a corner index to its (x,y) galvo codes.
//   idx_i - corner index: 0=(XMIN,YMIN) 1=(XMAX,YMIN) 2=(XMAX,YMAX) 3=(XMIN,YMAX)
//   x_o   - X code
//   y_o   - Y code
module setup_corner_lut import laser_setup_pkg::*; #(
   parameter int unsigned COORD_W = DefaultCoordW,
   parameter int unsigned X_MIN   = 0,
   parameter int unsigned X_MAX   = 4095,
   parameter int unsigned Y_MIN   = 0,
   parameter int unsigned Y_MAX   = 4095
) (
   input  corner_idx_t        idx_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o
);

   always_comb begin
      x_o = COORD_W'(X_MIN);
      y_o = COORD_W'(Y_MIN);
      unique case (idx_i)
         2'd0: begin x_o = COORD_W'(X_MIN); y_o = COORD_W'(Y_MIN); end
         2'd1: begin x_o = COORD_W'(X_MAX); y_o = COORD_W'(Y_MIN); end
         2'd2: begin x_o = COORD_W'(X_MAX); y_o = COORD_W'(Y_MAX); end
         2'd3: begin x_o = COORD_W'(X_MIN); y_o = COORD_W'(Y_MAX); end
      endcase
   end

endmodule

// File: rtl/setup_sequencer.sv
// setup_sequencer: runs the projector alignment pattern after power-up.
// On a rising edge of setup_start, visits the four field corners LOOPS times, offering each
// point to the galvo DAC driver and dwelling DWELL_CYCLES cycles with the laser on, then
// pulses setup_done for one cycle. All outputs are registered.
//   clk         - system clock
//   reset_n     - asynchronous active-low reset
//   setup_start - start request from the setup timer (rising edge)
//   setup_abort - abort request, present only when SETUP_ABORT_EN is defined
//   pt          - galvo point handshake (master side)
//   laser_on    - laser enable, high only while dwelling
//   busy        - high from start detection until done
//   setup_done  - one-cycle completion pulse
module setup_sequencer import laser_setup_pkg::*; #(
   parameter int unsigned COORD_W      = DefaultCoordW,
   parameter int unsigned X_MIN        = 0,
   parameter int unsigned X_MAX        = 4095,
   parameter int unsigned Y_MIN        = 0,
   parameter int unsigned Y_MAX        = 4095,
   parameter int unsigned DWELL_CYCLES = 2_700_000,
   parameter int unsigned LOOPS        = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              setup_start,
`ifdef SETUP_ABORT_EN
   input  logic              setup_abort,
`endif
   setup_sequencer_if.master pt,
   output logic              laser_on,
   output logic              busy,
   output logic              setup_done
);

   localparam int unsigned       CntW      = cnt_width(DWELL_CYCLES);
   localparam int unsigned       LoopW     = cnt_width(LOOPS);
   localparam logic [CntW-1:0]   DwellLast = CntW'(DWELL_CYCLES - 1);
   localparam logic [LoopW-1:0]  LoopLast  = LoopW'(LOOPS - 1);

   state_e             state_q, state_d;
   corner_idx_t        corner_q, corner_d;
   logic [LoopW-1:0]   loop_q, loop_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               start_q;
   logic               start_fire;
   logic               abort;
   logic [COORD_W-1:0] lut_x, lut_y;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               valid_q, valid_d;
   logic               laser_q, laser_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   assign start_fire = setup_start & ~start_q;

`ifdef SETUP_ABORT_EN
   assign abort = setup_abort & (state_q != StIdle);
`else
   assign abort = 1'b0;
`endif

   // Looks up the corner being entered so the registered coordinates line up with the state.
   setup_corner_lut #(
      .COORD_W (COORD_W),
      .X_MIN   (X_MIN),
      .X_MAX   (X_MAX),
      .Y_MIN   (Y_MIN),
      .Y_MAX   (Y_MAX)
   ) u_lut (
      .idx_i (corner_d),
      .x_o   (lut_x),
      .y_o   (lut_y)
   );

   always_comb begin
      state_d  = state_q;
      corner_d = corner_q;
      loop_d   = loop_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start_fire) begin
               state_d  = StSend;
               corner_d = '0;
               loop_d   = '0;
            end
         end
         StSend: begin
            // point_valid is high exactly in this state, so ready alone marks the transfer
            if (pt.point_ready) begin
               state_d = StDwell;
               cnt_d   = DwellLast;
            end
         end
         StDwell: begin
            if (cnt_q == '0) state_d = StNext;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StNext: begin
            if (corner_q == 2'd3 && loop_q == LoopLast) begin
               state_d = StDone;
            end else begin
               state_d  = StSend;
               corner_d = corner_q + 2'd1;
               if (corner_q == 2'd3) loop_d = loop_q + 1'b1;
            end
         end
         StDone: begin
            state_d  = StIdle;
            corner_d = '0;
            loop_d   = '0;
         end
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d  = StIdle;
         corner_d = '0;
         loop_d   = '0;
         cnt_d    = '0;
      end

      // Outputs are decoded from the next state and registered alongside it.
      busy_d  = (state_d != StIdle);
      valid_d = (state_d == StSend);
      laser_d = (state_d == StDwell);
      done_d  = (state_d == StDone);
      if (state_d inside {StSend, StDwell, StNext}) begin
         x_d = lut_x;
         y_d = lut_y;
      end else begin
         x_d = '0;
         y_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         corner_q <= '0;
         loop_q   <= '0;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         valid_q  <= 1'b0;
         laser_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         corner_q <= corner_d;
         loop_q   <= loop_d;
         cnt_q    <= cnt_d;
         start_q  <= setup_start;
         x_q      <= x_d;
         y_q      <= y_d;
         valid_q  <= valid_d;
         laser_q  <= laser_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign pt.point_x     = x_q;
   assign pt.point_y     = y_q;
   assign pt.point_valid = valid_q;
   assign laser_on       = laser_q;
   assign busy           = busy_q;
   assign setup_done     = done_q;

endmodule

// File: tb/tb_setup_sequencer.sv
// tb_setup_sequencer: self-checking bench for setup_sequencer (DWELL_CYCLES=3, LOOPS=2).
// Expected corner points are queued when a sequence is started and popped by a monitor on
// each accepted transfer. Define SETUP_ABORT_EN to include the abort scenario.
module tb_setup_sequencer;

   localparam int unsigned CW         = 12;
   localparam int unsigned DWELL      = 3;
   localparam int unsigned LOOPS      = 2;
   localparam int unsigned SEQ_CYCLES = 4 * LOOPS * (DWELL + 2);

   logic clk         = 1'b0;
   logic reset_n     = 1'b0;
   logic setup_start = 1'b0;
`ifdef SETUP_ABORT_EN
   logic setup_abort = 1'b0;
`endif
   logic laser_on;
   logic busy;
   logic setup_done;

   int n_tests  = 0;
   int n_fail   = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;

   logic [2*CW-1:0] exp_q[$];
   logic [2*CW-1:0] exp_xy;
   logic [2*CW-1:0] prev_xy;
   logic            prev_valid = 1'b0;
   logic            prev_ready = 1'b0;
   bit              laser_cut  = 1'b0;
   int              laser_run  = 0;

   setup_sequencer_if #(.COORD_W(CW)) pt_if ();

   setup_sequencer #(
      .COORD_W      (CW),
      .X_MIN        (0),
      .X_MAX        (4095),
      .Y_MIN        (0),
      .Y_MAX        (4095),
      .DWELL_CYCLES (DWELL),
      .LOOPS        (LOOPS)
   ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .setup_start (setup_start),
`ifdef SETUP_ABORT_EN
      .setup_abort (setup_abort),
`endif
      .pt          (pt_if),
      .laser_on    (laser_on),
      .busy        (busy),
      .setup_done  (setup_done)
   );

   always #5 clk = ~clk;

   function automatic logic [2*CW-1:0] corner_xy(int c);
      case (c)
         0:       return {12'd0,    12'd0};
         1:       return {12'd4095, 12'd0};
         2:       return {12'd4095, 12'd4095};
         default: return {12'd0,    12'd4095};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq();
      for (int l = 0; l < int'(LOOPS); l++)
         for (int c = 0; c < 4; c++) exp_q.push_back(corner_xy(c));
   endtask

   task automatic pulse_start();
      setup_start = 1'b1;
      step();
      setup_start = 1'b0;
   endtask

   // Monitor: scoreboard on transfers, hold stability, laser dwell length, done count.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            laser_run  = 0;
            laser_cut  = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
         end else begin
            if (prev_valid && !prev_ready) begin
               n_tests++;
               if (pt_if.point_valid !== 1'b1 || {pt_if.point_x, pt_if.point_y} !== prev_xy) begin
                  n_fail++;
                  $display("FAIL hold_stable: valid=%b xy=%h, required valid=1 xy=%h",
                           pt_if.point_valid, {pt_if.point_x, pt_if.point_y}, prev_xy);
               end
            end
            if (pt_if.point_valid === 1'b1 && pt_if.point_ready === 1'b1) begin
               n_tests++;
               xfer_cnt++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL xfer_unexpected: xy=%h, required no transfer",
                           {pt_if.point_x, pt_if.point_y});
               end else begin
                  exp_xy = exp_q.pop_front();
                  if ({pt_if.point_x, pt_if.point_y} !== exp_xy) begin
                     n_fail++;
                     $display("FAIL xfer_point: xy=%h, required %h",
                              {pt_if.point_x, pt_if.point_y}, exp_xy);
                  end
               end
            end
            if (pt_if.point_valid === 1'b1 && laser_on === 1'b1) begin
               n_tests++;
               n_fail++;
               $display("FAIL laser_blank: laser_on=1 with point_valid=1, required laser_on=0");
            end
            if (laser_on === 1'b1) begin
               laser_run++;
            end else if (laser_run != 0) begin
               if (!laser_cut) begin
                  n_tests++;
                  if (laser_run != int'(DWELL)) begin
                     n_fail++;
                     $display("FAIL dwell_len: laser high %0d cycles, required %0d",
                              laser_run, DWELL);
                  end
               end
               laser_cut = 1'b0;
               laser_run = 0;
            end
            if (setup_done === 1'b1) done_cnt++;
            prev_valid = pt_if.point_valid;
            prev_ready = pt_if.point_ready;
            prev_xy    = {pt_if.point_x, pt_if.point_y};
         end
      end
   end

   task automatic test_reset();
      reset_n = 1'b0;
      setup_start = 1'b0;
      pt_if.point_ready = 1'b0;
      step();
      step();
      n_tests++;
      if ({pt_if.point_valid, laser_on, busy, setup_done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: valid,laser,busy,done=%b, required 0000",
                  {pt_if.point_valid, laser_on, busy, setup_done});
      end
      n_tests++;
      if ({pt_if.point_x, pt_if.point_y} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_xy: xy=%h, required 000000", {pt_if.point_x, pt_if.point_y});
      end
      reset_n = 1'b1;
      step();
      step();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_sequence();
      int  bx, bd, cyc;
      bit  got;
      pt_if.point_ready = 1'b1;
      push_seq();
      bx = xfer_cnt;
      bd = done_cnt;
      pulse_start();
      n_tests++;
      if ({busy, pt_if.point_valid, laser_on} !== 3'b110 || {pt_if.point_x, pt_if.point_y} !== 24'h0)
      begin
         n_fail++;
         $display("FAIL start_first_point: busy,valid,laser=%b xy=%h, required 110 xy=000000",
                  {busy, pt_if.point_valid, laser_on}, {pt_if.point_x, pt_if.point_y});
      end
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < int'(SEQ_CYCLES) + 20) begin
         step();
         cyc++;
         if (setup_done === 1'b1) got = 1'b1;
      end
      n_tests++;
      if (!got || cyc != int'(SEQ_CYCLES)) begin
         n_fail++;
         $display("FAIL done_latency: done seen=%0d after %0d cycles, required 1 after %0d",
                  got, cyc, SEQ_CYCLES);
      end
      step();
      n_tests++;
      if ({setup_done, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL done_width: done,busy=%b one cycle later, required 00", {setup_done, busy});
      end
      n_tests++;
      if (xfer_cnt - bx != int'(4 * LOOPS) || done_cnt - bd != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL seq_counts: xfers=%0d dones=%0d left=%0d, required %0d 1 0",
                  xfer_cnt - bx, done_cnt - bd, exp_q.size(), 4 * LOOPS);
      end
   endtask

   task automatic test_backpressure();
      int bx, cyc;
      bit found;
      pt_if.point_ready = 1'b1;
      push_seq();
      bx = xfer_cnt;
      pulse_start();
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 50) begin
         if (pt_if.point_valid === 1'b1 && pt_if.point_x === 12'd4095 && pt_if.point_y === 12'd0)
            found = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      pt_if.point_ready = 1'b0;
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL bp_corner1_seen: found=0 after %0d cycles, required 1", cyc);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         n_tests++;
         if ({pt_if.point_valid, laser_on} !== 2'b10 ||
             {pt_if.point_x, pt_if.point_y} !== {12'd4095, 12'd0}) begin
            n_fail++;
            $display("FAIL bp_hold: cycle %0d valid,laser=%b xy=%h, required 10 xy=fff000",
                     i, {pt_if.point_valid, laser_on}, {pt_if.point_x, pt_if.point_y});
         end
      end
      pt_if.point_ready = 1'b1;
      step();
      n_tests++;
      if ({pt_if.point_valid, laser_on} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_dwell_start: valid,laser=%b after accept, required 01",
                  {pt_if.point_valid, laser_on});
      end
      cyc = 0;
      while (setup_done !== 1'b1 && cyc < int'(SEQ_CYCLES) + 40) begin
         step();
         cyc++;
      end
      step();
      n_tests++;
      if (xfer_cnt - bx != int'(4 * LOOPS) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_complete: xfers=%0d busy=%b, required %0d busy=0",
                  xfer_cnt - bx, busy, 4 * LOOPS);
      end
   endtask

   task automatic test_back_to_back();
      int bx, bd, cyc;
      pt_if.point_ready = 1'b1;
      push_seq();
      bx = xfer_cnt;
      bd = done_cnt;
      pulse_start();
      repeat (7) step();
      pulse_start();
      cyc = 0;
      while (setup_done !== 1'b1 && cyc < int'(SEQ_CYCLES) + 20) begin
         step();
         cyc++;
      end
      repeat (SEQ_CYCLES / 2) step();
      n_tests++;
      if (xfer_cnt - bx != int'(4 * LOOPS) || done_cnt - bd != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_ignored_busy: xfers=%0d dones=%0d busy=%b, required %0d 1 0",
                  xfer_cnt - bx, done_cnt - bd, busy, 4 * LOOPS);
      end
   endtask

   task automatic test_reset_mid();
      int bx, bd, cyc;
      bit found;
      pt_if.point_ready = 1'b1;
      push_seq();
      pulse_start();
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 60) begin
         if (laser_on === 1'b1 && pt_if.point_x === 12'd4095 && pt_if.point_y === 12'd4095)
            found = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL rst_corner2_dwell_seen: found=0, required 1");
      end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({laser_on, pt_if.point_valid, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_async: laser,valid,busy=%b right after reset, required 000",
                  {laser_on, pt_if.point_valid, busy});
      end
      exp_q.delete();
      // Level already high at reset release must start exactly one sequence.
      setup_start = 1'b1;
      step();
      reset_n = 1'b1;
      push_seq();
      bx = xfer_cnt;
      bd = done_cnt;
      step();
      n_tests++;
      if ({busy, pt_if.point_valid} !== 2'b11 || {pt_if.point_x, pt_if.point_y} !== 24'h0) begin
         n_fail++;
         $display("FAIL rst_restart_corner0: busy,valid=%b xy=%h, required 11 xy=000000",
                  {busy, pt_if.point_valid}, {pt_if.point_x, pt_if.point_y});
      end
      cyc = 0;
      while (setup_done !== 1'b1 && cyc < int'(SEQ_CYCLES) + 20) begin
         step();
         cyc++;
      end
      repeat (SEQ_CYCLES / 2) step();
      n_tests++;
      if (xfer_cnt - bx != int'(4 * LOOPS) || done_cnt - bd != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_level_once: xfers=%0d dones=%0d busy=%b, required %0d 1 0",
                  xfer_cnt - bx, done_cnt - bd, busy, 4 * LOOPS);
      end
      setup_start = 1'b0;
      step();
   endtask

`ifdef SETUP_ABORT_EN
   task automatic test_abort();
      int bd, cyc;
      bit found;
      pt_if.point_ready = 1'b1;
      push_seq();
      bd = done_cnt;
      pulse_start();
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 40) begin
         if (laser_on === 1'b1 && pt_if.point_x === 12'd4095 && pt_if.point_y === 12'd0)
            found = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      laser_cut = 1'b1;
      setup_abort = 1'b1;
      step();
      setup_abort = 1'b0;
      exp_q.delete();
      n_tests++;
      if (!found || {busy, pt_if.point_valid, laser_on, setup_done} !== 4'b0000 ||
          {pt_if.point_x, pt_if.point_y} !== 24'h0) begin
         n_fail++;
         $display("FAIL abort_dwell: found=%0d busy,valid,laser,done=%b xy=%h, required 1 0000 0",
                  found, {busy, pt_if.point_valid, laser_on, setup_done},
                  {pt_if.point_x, pt_if.point_y});
      end
      repeat (5) step();
      n_tests++;
      if (done_cnt != bd || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: dones=%0d busy=%b, required 0 0", done_cnt - bd, busy);
      end
      setup_abort = 1'b1;
      step();
      setup_abort = 1'b0;
      push_seq();
      pulse_start();
      n_tests++;
      if ({busy, pt_if.point_valid} !== 2'b11) begin
         n_fail++;
         $display("FAIL abort_idle_noeffect: busy,valid=%b after start, required 11",
                  {busy, pt_if.point_valid});
      end
      cyc = 0;
      while (setup_done !== 1'b1 && cyc < int'(SEQ_CYCLES) + 20) begin
         step();
         cyc++;
      end
      step();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_sequence();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef SETUP_ABORT_EN
      test_abort();
`endif
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
